// File: rtl/lz4_pixel_packer.sv
// lz4_pixel_packer: assembles RGB888/RGB565 pixels from the LZ4 byte stream into a FIFO and
// throttles the decoder through run, reporting frame completion and error.
module lz4_pixel_packer #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] frame_pixels,
   input  logic        rgb565,
   input  logic [7:0]  uncompressed_byte,
   input  logic        data_valid,
   input  logic        lz4_done,
   input  logic        lz4_error,
   output logic        run,
   output logic [23:0] pixel,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic [31:0] pixel_count,
   output logic        frame_done,
   output logic        frame_error
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] RUN_LIM = (AW+1)'(DEPTH - 2);

   typedef enum logic [1:0] {S_Idle, S_Fill, S_Drain, S_Done} state_t;

   state_t      r_state, w_next;
   logic        r_565, r_err, r_run;
   logic [31:0] r_np, r_count;
   logic [1:0]  r_phase;
   logic [7:0]  r_b0, r_b1;
   logic [23:0] r_mem [DEPTH];
   logic [AW:0] r_wp, r_rp;

   logic [AW:0] w_occ;
   logic        w_empty, w_last, w_push, w_pop, w_arm, w_err_set;
   logic [15:0] w_word;
   logic [23:0] w_px;
   logic [31:0] w_np, w_cnt;

   assign w_occ   = r_wp - r_rp;
   assign w_empty = (w_occ == '0);
   assign w_last  = data_valid && (r_phase == (r_565 ? 2'd1 : 2'd2));
   assign w_push  = (r_state == S_Fill) && w_last;
   assign w_pop   = !w_empty && pixel_ready;
   assign w_word  = {uncompressed_byte, r_b0};
   assign w_px    = r_565 ? {w_word[15:11], w_word[15:13], w_word[10:5], w_word[10:9],
                             w_word[4:0], w_word[4:2]}
                          : {r_b0, r_b1, uncompressed_byte};
   assign w_arm   = start && (r_state == S_Idle || r_state == S_Done);
   assign w_np    = w_arm ? frame_pixels : r_np;
   assign w_cnt   = w_arm ? '0 : r_count + 32'(w_push);
   assign w_err_set = (r_state != S_Idle && lz4_done && lz4_error)
                   || (r_state == S_Fill && lz4_done && w_cnt != r_np)
                   || (r_state == S_Drain && data_valid);

   always_comb begin
      w_next = r_state;
      if (w_arm)
         w_next = S_Fill;
      else if (r_state == S_Fill && (w_cnt == r_np || lz4_done))
         w_next = S_Drain;
      else if (r_state == S_Drain && w_empty)
         w_next = S_Done;
   end

   // run looks at the next state so it rises one cycle after start and drops with the last pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_Idle;
         r_run   <= 1'b0;
         r_565   <= 1'b0;
         r_err   <= 1'b0;
         r_np    <= '0;
         r_count <= '0;
         r_phase <= '0;
         r_b0    <= '0;
         r_b1    <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
      end else begin
         r_state <= w_next;
         r_run   <= (w_next == S_Fill) && (w_occ < RUN_LIM) && (w_cnt < w_np);
         r_np    <= w_np;
         r_count <= w_cnt;
         if (w_arm) begin
            r_565   <= rgb565;
            r_phase <= '0;
            r_err   <= 1'b0;
         end else begin
            if (w_err_set)
               r_err <= 1'b1;
            if (r_state == S_Fill && data_valid) begin
               r_phase <= w_last ? 2'd0 : r_phase + 2'd1;
               if (r_phase == 2'd0)
                  r_b0 <= uncompressed_byte;
               if (r_phase == 2'd1)
                  r_b1 <= uncompressed_byte;
            end
            if (w_next == S_Drain)
               r_phase <= '0;
         end
         if (w_push)
            r_wp <= r_wp + 1'b1;
         if (w_pop)
            r_rp <= r_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !reset)
         r_mem[r_wp[AW-1:0]] <= w_px;
   end

   assign run         = r_run;
   assign pixel       = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
   assign pixel_valid = !w_empty;
   assign pixel_count = r_count;
   assign frame_done  = (r_state == S_Done);
   assign frame_error = frame_done && r_err;
endmodule

// File: tb/tb_lz4_pixel_packer.sv
// tb_lz4_pixel_packer: directed vectors and corner-case sequences for lz4_pixel_packer (DEPTH=4).
module tb_lz4_pixel_packer;
   logic        clk = 0, reset = 1, start = 0, rgb565 = 0, data_valid = 0;
   logic        lz4_done = 0, lz4_error = 0, pixel_ready = 0;
   logic [31:0] frame_pixels = 0;
   logic [7:0]  uncompressed_byte = 0;
   logic        run, pixel_valid, frame_done, frame_error;
   logic [23:0] pixel;
   logic [31:0] pixel_count;

   int n_cmp = 0, n_bad = 0;
   logic [7:0]  bq[$];
   logic [23:0] got[$];

   lz4_pixel_packer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .frame_pixels(frame_pixels), .rgb565(rgb565),
      .uncompressed_byte(uncompressed_byte), .data_valid(data_valid), .lz4_done(lz4_done),
      .lz4_error(lz4_error), .run(run), .pixel(pixel), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .pixel_count(pixel_count), .frame_done(frame_done),
      .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!reset && pixel_valid && pixel_ready)
         got.push_back(pixel);

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_got(input string nm, input int k, input logic [23:0] exp);
      chk(nm, (k < got.size()) ? 32'(got[k]) : 32'hdead_beef, 32'(exp));
   endtask

   task automatic do_start(input logic [31:0] n, input logic m);
      start = 1;
      frame_pixels = n;
      rgb565 = m;
      tick();
      start = 0;
   endtask

   // decoder model: emits a byte in every cycle where run is high
   task automatic feed();
      int g = 0;
      while (bq.size() > 0 && g < 2000) begin
         if (run) begin
            uncompressed_byte = bq.pop_front();
            data_valid = 1;
         end else
            data_valid = 0;
         tick();
         g++;
      end
      data_valid = 0;
      chk("feed_timeout", 32'(bq.size()), 0);
   endtask

   task automatic wait_done();
      int g = 0;
      while (!frame_done && g < 500) begin
         tick();
         g++;
      end
      chk("frame_done", 32'(frame_done), 1);
   endtask

   function automatic logic [23:0] exp565(input logic [15:0] w);
      return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
   endfunction

   typedef struct {
      logic        m;
      logic [7:0]  b0, b1, b2;
      logic [23:0] exp;
   } vec_t;

   initial begin
      vec_t tv[7];
      tv[0] = '{0, 8'h11, 8'h12, 8'h13, 24'h111213};
      tv[1] = '{1, 8'h1F, 8'hF8, 8'h00, 24'hFF00FF};
      tv[2] = '{1, 8'hE0, 8'h07, 8'h00, 24'h00FF00};
      tv[3] = '{1, 8'h41, 8'h08, 8'h00, 24'h080808};
      tv[4] = '{0, 8'hFF, 8'h00, 8'hA5, 24'hFF00A5};
      tv[5] = '{1, 8'hFF, 8'hFF, 8'h00, 24'hFFFFFF};
      tv[6] = '{1, 8'h00, 8'h00, 8'h00, 24'h000000};

      tick(); tick();
      reset = 0;
      chk("rst_run", 32'(run), 0);
      chk("rst_valid", 32'(pixel_valid), 0);
      chk("rst_pixel", 32'(pixel), 0);
      chk("rst_count", pixel_count, 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_err", 32'(frame_error), 0);

      // single-pixel frames, pixel checked in the FIFO one cycle after its last byte
      for (int i = 0; i < 7; i++) begin
         pixel_ready = 0;
         got.delete();
         do_start(1, tv[i].m);
         chk("run_after_start", 32'(run), 1);
         bq.push_back(tv[i].b0);
         bq.push_back(tv[i].b1);
         if (!tv[i].m) bq.push_back(tv[i].b2);
         feed();
         chk("vec_valid", 32'(pixel_valid), 1);
         chk("vec_pixel", 32'(pixel), 32'(tv[i].exp));
         chk("vec_run_off", 32'(run), 0);
         pixel_ready = 1;
         wait_done();
         chk("vec_err", 32'(frame_error), 0);
         chk_got("vec_popped", 0, tv[i].exp);
      end

      // RGB888 four-pixel frame, continuous ready
      got.delete();
      pixel_ready = 1;
      do_start(4, 0);
      for (int b = 8'h11; b <= 8'h1C; b++) bq.push_back(8'(b));
      feed();
      wait_done();
      chk("f888_err", 32'(frame_error), 0);
      chk("f888_count", pixel_count, 4);
      chk("f888_n", 32'(got.size()), 4);
      chk_got("f888_p0", 0, 24'h111213);
      chk_got("f888_p1", 1, 24'h141516);
      chk_got("f888_p2", 2, 24'h171819);
      chk_got("f888_p3", 3, 24'h1A1B1C);

      // backpressure: run stalls with two entries free, nothing lost afterwards
      got.delete();
      pixel_ready = 0;
      do_start(6, 1);
      for (int k = 0; k < 6; k++) begin
         logic [15:0] w;
         w = 16'h1234 + 16'(k) * 16'h1111;
         bq.push_back(w[7:0]);
         bq.push_back(w[15:8]);
      end
      fork
         feed();
         begin
            repeat (15) tick();
            chk("bp_run_low", 32'(run), 0);
            chk("bp_count", pixel_count, 2);
            chk("bp_valid", 32'(pixel_valid), 1);
            pixel_ready = 1;
         end
      join
      wait_done();
      chk("bp_err", 32'(frame_error), 0);
      chk("bp_n", 32'(got.size()), 6);
      for (int k = 0; k < 6; k++)
         chk_got("bp_px", k, exp565(16'h1234 + 16'(k) * 16'h1111));

      // short stream: decoder finishes after 7 of 10 pixels
      got.delete();
      do_start(10, 0);
      for (int b = 0; b < 21; b++) bq.push_back(8'(8'h40 + b));
      feed();
      lz4_done = 1;
      wait_done();
      lz4_done = 0;
      chk("short_err", 32'(frame_error), 1);
      chk("short_count", pixel_count, 7);
      chk("short_n", 32'(got.size()), 7);
      chk_got("short_last", 6, 24'h525354);

      // over-long stream: two extra bytes after the final pixel
      got.delete();
      do_start(4, 1);
      for (int b = 0; b < 8; b++) bq.push_back(8'(8'h20 + b));
      feed();
      data_valid = 1;
      uncompressed_byte = 8'h99;
      tick(); tick();
      data_valid = 0;
      wait_done();
      chk("long_err", 32'(frame_error), 1);
      chk("long_count", pixel_count, 4);
      repeat (3) tick();
      chk("long_n", 32'(got.size()), 4);
      chk_got("long_p3", 3, exp565(16'h2726));

      // reset in the middle of a pixel
      got.delete();
      pixel_ready = 0;
      do_start(2, 0);
      bq.push_back(8'hAA);
      feed();
      reset = 1;
      tick();
      reset = 0;
      chk("mr_run", 32'(run), 0);
      chk("mr_valid", 32'(pixel_valid), 0);
      chk("mr_pixel", 32'(pixel), 0);
      chk("mr_count", pixel_count, 0);
      chk("mr_done", 32'(frame_done), 0);
      chk("mr_err", 32'(frame_error), 0);
      pixel_ready = 1;
      do_start(1, 1);
      bq.push_back(8'h1F);
      bq.push_back(8'hF8);
      feed();
      wait_done();
      chk("mr_new_err", 32'(frame_error), 0);
      chk("mr_new_n", 32'(got.size()), 1);
      chk_got("mr_new_px", 0, 24'hFF00FF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
